// File: rtl/instr_sequencer.sv
// Fetch/issue sequencer for the instruction decoder: owns the PC, fetches from a sync-read
// program memory, applies the +/- condition flag, and handles jumps, timed sleep and wrap-around.
module instr_sequencer #(
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned PROG_LEN = 14,
   parameter int unsigned TICK_CYC = 4,
   parameter int unsigned SLP_W    = 11
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   output logic [ADDR_W-1:0]       imem_addr,
   input  logic [30:0]             imem_rdata,
   output logic [30:0]             instr,
   output logic                    instr_valid,
   input  logic                    is_jmp,
   input  logic                    is_slp,
   input  logic                    is_cond,
   input  logic                    cond_result,
   input  logic signed [SLP_W-1:0] slp_val,
   output logic [ADDR_W-1:0]       pc,
   output logic [1:0]              flag,
   output logic                    sleeping
);

   localparam int unsigned CNT_W = SLP_W + $clog2(TICK_CYC);

   localparam logic [1:0] FLAG_NONE  = 2'b00;
   localparam logic [1:0] FLAG_PLUS  = 2'b01;
   localparam logic [1:0] FLAG_MINUS = 2'b10;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_SLEEP = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
   logic [1:0]         flag_q, flag_d;
   logic [CNT_W-1:0]   sleep_cnt_q, sleep_cnt_d;
   logic               sleeping_q, sleeping_d;

   logic [ADDR_W-1:0]  pc_inc;
   logic [ADDR_W-1:0]  jmp_tgt;
   logic               run;
   logic               slp_pos;
   logic [CNT_W-1:0]   sleep_load;

   // Datapath helpers: wrap-around increment, clamped jump target, prefix gate, sleep length.
   always_comb begin
      pc_inc     = (pc_q == ADDR_W'(PROG_LEN - 1)) ? '0 : pc_q + ADDR_W'(1);
      jmp_tgt    = (32'(imem_rdata[ADDR_W-1:0]) < PROG_LEN) ? imem_rdata[ADDR_W-1:0] : '0;
      unique case (imem_rdata[30:29])
         2'b10:   run = (flag_q == FLAG_PLUS);
         2'b11:   run = (flag_q == FLAG_MINUS);
         default: run = 1'b1;
      endcase
      slp_pos    = !slp_val[SLP_W-1] && (|slp_val[SLP_W-2:0]);
      sleep_load = CNT_W'(slp_val[SLP_W-2:0]) * CNT_W'(TICK_CYC) - CNT_W'(1);
   end

   // Next-state and issue logic; instr/instr_valid follow memory data in EXEC.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      flag_d      = flag_q;
      sleep_cnt_d = sleep_cnt_q;
      instr       = '0;
      instr_valid = 1'b0;

      unique case (state_q)
         ST_FETCH: begin
            if (en) state_d = ST_EXEC;
         end
         ST_EXEC: begin
            state_d = ST_FETCH;
            if (!run) begin
               pc_d = pc_inc;
            end else begin
               instr       = imem_rdata;
               instr_valid = 1'b1;
               if (is_jmp) begin
                  pc_d = jmp_tgt;
               end else if (is_slp && slp_pos) begin
                  pc_d        = pc_inc;
                  sleep_cnt_d = sleep_load;
                  state_d     = ST_SLEEP;
               end else begin
                  pc_d = pc_inc;
                  if (is_cond) flag_d = cond_result ? FLAG_PLUS : FLAG_MINUS;
               end
            end
         end
         ST_SLEEP: begin
            if (sleep_cnt_q == '0) state_d = ST_FETCH;
            else                   sleep_cnt_d = sleep_cnt_q - CNT_W'(1);
         end
         default: state_d = ST_FETCH;
      endcase

      imem_addr_d = pc_d;
      sleeping_d  = (state_d == ST_SLEEP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_FETCH;
         pc_q        <= '0;
         imem_addr_q <= '0;
         flag_q      <= FLAG_NONE;
         sleep_cnt_q <= '0;
         sleeping_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         imem_addr_q <= imem_addr_d;
         flag_q      <= flag_d;
         sleep_cnt_q <= sleep_cnt_d;
         sleeping_q  <= sleeping_d;
      end
   end

   assign imem_addr = imem_addr_q;
   assign pc        = pc_q;
   assign flag      = flag_q;
   assign sleeping  = sleeping_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed trace table, hand-written reset/linear sequences and a
// randomized program run checked against an instruction-level reference model.
module tb_instr_sequencer;

   localparam int unsigned ADDR_W   = 4;
   localparam int unsigned PROG_LEN = 14;
   localparam int unsigned TICK_CYC = 4;
   localparam int unsigned SLP_W    = 11;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    en;
   logic [ADDR_W-1:0]       imem_addr;
   logic [30:0]             imem_rdata;
   logic [30:0]             instr;
   logic                    instr_valid;
   logic                    is_jmp, is_slp, is_cond, cond_result;
   logic signed [SLP_W-1:0] slp_val;
   logic [ADDR_W-1:0]       pc;
   logic [1:0]              flag;
   logic                    sleeping;

   instr_sequencer #(
      .ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN), .TICK_CYC(TICK_CYC), .SLP_W(SLP_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .instr(instr), .instr_valid(instr_valid), .is_jmp(is_jmp), .is_slp(is_slp),
      .is_cond(is_cond), .cond_result(cond_result), .slp_val(slp_val), .pc(pc),
      .flag(flag), .sleeping(sleeping)
   );

   always #5 clk = ~clk;

   // Program memory with one-cycle synchronous read.
   logic [30:0] mem [16];
   always @(posedge clk) imem_rdata <= mem[imem_addr];

   // Toy decoder: opcode in [28:26]; 1 JMPI, 2 SLPI, 3 TEQ, others NOP-class.
   always_comb begin
      is_jmp      = (instr[28:26] == 3'd1);
      is_slp      = (instr[28:26] == 3'd2);
      is_cond     = (instr[28:26] == 3'd3);
      cond_result = instr[11];
      slp_val     = instr[10:0];
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [30:0] mk(input logic [1:0] pfx, input logic [2:0] op,
                                      input logic [11:0] lo);
      return {pfx, op, 14'd0, lo};
   endfunction

   function automatic logic [11:0] sv(input int v);
      return 12'(v) & 12'h7FF;
   endfunction

   // Instruction-level reference model.
   int       m_pc;
   logic [1:0] m_flag;

   task automatic model_step(output logic v, output int slp);
      logic [30:0] w;
      int          nxt, sval;
      w    = mem[m_pc];
      v    = (w[30:29] == 2'b10) ? (m_flag == 2'b01) :
             (w[30:29] == 2'b11) ? (m_flag == 2'b10) : 1'b1;
      slp  = 0;
      nxt  = (m_pc + 1) % PROG_LEN;
      sval = int'($signed(w[10:0]));
      if (v) begin
         case (w[28:26])
            3'd1: nxt = (int'(w[3:0]) < PROG_LEN) ? int'(w[3:0]) : 0;
            3'd2: if (sval > 0) slp = sval * TICK_CYC;
            3'd3: m_flag = w[11] ? 2'b01 : 2'b10;
            default: ;
         endcase
      end
      m_pc = nxt;
   endtask

   typedef struct {
      logic [3:0]  exec_pc;
      logic        valid;
      logic [30:0] ins;
      logic [3:0]  next_pc;
      logic [1:0]  flg;
      int          slp;
   } obs_t;

   // Runs one instruction from a FETCH-state negedge, stalling first; returns observations.
   task automatic do_instr(input int stall, output obs_t o);
      logic [3:0] a0, p0;
      int n;
      chk("fetch_valid_low", 32'(instr_valid), 0);
      a0 = imem_addr;
      p0 = pc;
      for (int k = 0; k < stall; k++) begin
         en = 1'b0;
         @(negedge clk);
         chk("stall_valid", 32'(instr_valid), 0);
         chk("stall_addr", 32'(imem_addr), 32'(a0));
         chk("stall_pc", 32'(pc), 32'(p0));
      end
      en = 1'b1;
      @(negedge clk);
      o.exec_pc = pc;
      o.valid   = instr_valid;
      o.ins     = instr;
      en        = 1'($urandom);
      @(negedge clk);
      o.next_pc = pc;
      o.flg     = flag;
      chk("addr_eq_pc", 32'(imem_addr), 32'(pc));
      n = 0;
      while (sleeping === 1'b1 && n < 5000) begin
         n++;
         chk("sleep_no_issue", {1'b0, instr}, 0);
         en = 1'($urandom);
         @(negedge clk);
      end
      o.slp = n;
      en    = 1'b0;
   endtask

   task automatic cmp_obs(input obs_t o, input int e_pc, input logic e_v, input int e_nxt,
                          input logic [1:0] e_flag, input int e_slp);
      chk("exec_pc", 32'(o.exec_pc), 32'(e_pc));
      chk("instr_valid", 32'(o.valid), 32'(e_v));
      chk("instr", {1'b0, o.ins}, e_v ? {1'b0, mem[e_pc]} : 32'd0);
      chk("next_pc", 32'(o.next_pc), 32'(e_nxt));
      chk("flag", 32'(o.flg), 32'(e_flag));
      chk("sleep_len", 32'(o.slp), 32'(e_slp));
   endtask

   task automatic do_reset();
      en    = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_pc", 32'(pc), 0);
      chk("rst_addr", 32'(imem_addr), 0);
      chk("rst_instr", {1'b0, instr}, 0);
      chk("rst_valid", 32'(instr_valid), 0);
      chk("rst_flag", 32'(flag), 0);
      chk("rst_sleeping", 32'(sleeping), 0);
      rst_n  = 1'b1;
      m_pc   = 0;
      m_flag = 2'b00;
   endtask

   typedef struct {
      int         stall;
      int         pc;
      logic       v;
      int         nxt;
      logic [1:0] flg;
      int         slp;
   } vec_t;

   vec_t  tbl [14];
   obs_t  o;
   logic  ev;
   int    es, epc, vcount;

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      m_pc  = 0;
      m_flag = 2'b00;
      for (int i = 0; i < 16; i++) mem[i] = '0;

      // Directed program and expected execution trace.
      mem[0]  = mk(2'b00, 3'd3, 12'h800);
      mem[1]  = mk(2'b10, 3'd0, 12'h123);
      mem[2]  = mk(2'b11, 3'd0, 12'h045);
      mem[3]  = mk(2'b00, 3'd3, 12'h000);
      mem[4]  = mk(2'b10, 3'd3, 12'h800);
      mem[5]  = mk(2'b11, 3'd0, 12'h0AA);
      mem[6]  = mk(2'b00, 3'd2, sv(3));
      mem[7]  = mk(2'b00, 3'd2, sv(0));
      mem[8]  = mk(2'b00, 3'd2, sv(-5));
      mem[9]  = mk(2'b00, 3'd1, 12'd11);
      mem[10] = mk(2'b00, 3'd1, 12'd9);
      mem[11] = mk(2'b01, 3'd0, 12'h055);
      mem[12] = mk(2'b11, 3'd1, 12'd15);
      mem[13] = mk(2'b00, 3'd0, 12'h000);
      tbl[0]  = '{7,  0, 1'b1,  1, 2'b01, 0};
      tbl[1]  = '{0,  1, 1'b1,  2, 2'b01, 0};
      tbl[2]  = '{1,  2, 1'b0,  3, 2'b01, 0};
      tbl[3]  = '{0,  3, 1'b1,  4, 2'b10, 0};
      tbl[4]  = '{0,  4, 1'b0,  5, 2'b10, 0};
      tbl[5]  = '{2,  5, 1'b1,  6, 2'b10, 0};
      tbl[6]  = '{0,  6, 1'b1,  7, 2'b10, 12};
      tbl[7]  = '{0,  7, 1'b1,  8, 2'b10, 0};
      tbl[8]  = '{0,  8, 1'b1,  9, 2'b10, 0};
      tbl[9]  = '{0,  9, 1'b1, 11, 2'b10, 0};
      tbl[10] = '{0, 11, 1'b1, 12, 2'b10, 0};
      tbl[11] = '{0, 12, 1'b1,  0, 2'b10, 0};
      tbl[12] = '{3,  0, 1'b1,  1, 2'b01, 0};
      tbl[13] = '{0,  1, 1'b1,  2, 2'b01, 0};

      do_reset();
      for (int i = 0; i < 14; i++) begin
         do_instr(tbl[i].stall, o);
         cmp_obs(o, tbl[i].pc, tbl[i].v, tbl[i].nxt, tbl[i].flg, tbl[i].slp);
      end

      // Linear: 14 NOP-class lines, two laps, wrap 13 -> 0.
      rst_n = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = mk(2'(i % 2), 3'd0, 12'($urandom));
      do_reset();
      vcount = 0;
      for (int i = 0; i < 2 * PROG_LEN; i++) begin
         epc = m_pc;
         model_step(ev, es);
         do_instr(0, o);
         if (o.valid) vcount++;
         cmp_obs(o, epc, ev, m_pc, m_flag, es);
      end
      chk("linear_valid_pulses", 32'(vcount), 32'(2 * PROG_LEN));

      // Reset in the middle of a 12-cycle sleep, with a live flag.
      rst_n  = 1'b0;
      mem[0] = mk(2'b00, 3'd3, 12'h800);
      mem[1] = mk(2'b00, 3'd2, sv(3));
      do_reset();
      do_instr(0, o);
      chk("pre_sleep_flag", 32'(flag), 32'd1);
      en = 1'b1;
      @(negedge clk);
      chk("sleep_exec_valid", 32'(instr_valid), 1);
      en = 1'b0;
      @(negedge clk);
      chk("sleep_entered", 32'(sleeping), 1);
      repeat (4) @(negedge clk);
      chk("sleep_cycle5", 32'(sleeping), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midsleep_rst_pc", 32'(pc), 0);
      chk("midsleep_rst_sleeping", 32'(sleeping), 0);
      chk("midsleep_rst_flag", 32'(flag), 0);
      chk("midsleep_rst_instr", {1'b0, instr}, 0);
      chk("midsleep_rst_addr", 32'(imem_addr), 0);
      @(negedge clk);
      rst_n  = 1'b1;
      m_pc   = 0;
      m_flag = 2'b00;
      for (int i = 0; i < 2; i++) begin
         epc = m_pc;
         model_step(ev, es);
         do_instr(0, o);
         cmp_obs(o, epc, ev, m_pc, m_flag, es);
      end

      // Random programs against the reference model.
      for (int r = 0; r < 3; r++) begin
         rst_n = 1'b0;
         for (int i = 0; i < 16; i++)
            mem[i] = mk(2'($urandom_range(3)), 3'($urandom_range(4)),
                        ($urandom_range(3) == 0) ? 12'($urandom_range(15)) :
                        {1'($urandom), sv($urandom_range(8) - 4)});
         do_reset();
         for (int i = 0; i < 60; i++) begin
            epc = m_pc;
            model_step(ev, es);
            do_instr($urandom_range(3) == 0 ? $urandom_range(3) : 0, o);
            cmp_obs(o, epc, ev, m_pc, m_flag, es);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
